// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost flags, occupancy count, sticky
// overflow/underflow errors and a selectable first-word-fall-through read port.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AE_LEVEL   = 6,
  parameter int AF_LEVEL   = 1018,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  almost_empty_flag,
  output logic                  almost_full_flag,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = CW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_cfg_err
    $error("fifo_sync_param: illegal AE_LEVEL/AF_LEVEL for this depth");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ae_q, ae_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_ok, rd_ok;

  // Acceptance uses the registered flags, so a full FIFO never takes a write
  // and an empty one never gives a read, whatever else happens that cycle.
  always_comb begin
    wr_ok    = we & ~full_q;
    rd_ok    = re & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_CNT);
    ae_d    = (count_d <= AE_CNT);
    af_d    = (count_d >= AF_CNT);
    ovf_d   = ovf_q | (we & full_q);
    udf_d   = udf_q | (re & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr_q] <= di;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown as soon as the FIFO is non-empty; forced to zero
    // while empty so the port reads as cleared after reset.
    assign dout     = empty_q ? '0 : mem[rd_ptr_q];
    assign rd_valid = ~empty_q;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      dout_d     = rd_ok ? mem[rd_ptr_q] : dout_q;
      rd_valid_d = rd_ok;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
  end

  assign empty_flag        = empty_q;
  assign full_flag         = full_q;
  assign almost_empty_flag = ae_q;
  assign almost_full_flag  = af_q;
  assign count             = count_q;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: one standard-mode and one FWFT instance
// (DEPTH=16, AE=2, AF=14) driven from shared inputs.
module tb_fifo_sync_param;

  logic       clk;
  logic       rst;
  logic [7:0] di;
  logic       we;
  logic       re;

  logic [7:0] s_dout, f_dout;
  logic       s_rv, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic       f_rv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [4:0] s_count, f_count;

  int checks = 0;
  int errors = 0;

  fifo_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AE_LEVEL(2), .AF_LEVEL(14), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .di(di), .we(we), .re(re),
    .dout(s_dout), .rd_valid(s_rv), .empty_flag(s_empty), .full_flag(s_full),
    .almost_empty_flag(s_ae), .almost_full_flag(s_af), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AE_LEVEL(2), .AF_LEVEL(14), .FWFT(1)
  ) u_fw (
    .clk(clk), .rst(rst), .di(di), .we(we), .re(re),
    .dout(f_dout), .rd_valid(f_rv), .empty_flag(f_empty), .full_flag(f_full),
    .almost_empty_flag(f_ae), .almost_full_flag(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; di = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (s_count !== 5'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", s_count);
    end
    checks++;
    if ({s_empty, s_ae, s_af, s_full} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: got %b want 1100", {s_empty, s_ae, s_af, s_full});
    end
    checks++;
    if ({s_dout, s_rv, s_ovf, s_udf} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs: got dout=%h rv=%b ovf=%b udf=%b want all 0",
                          s_dout, s_rv, s_ovf, s_udf);
    end
  endtask

  task automatic test_fill();
    logic [3:0] ef;
    for (int i = 1; i <= 16; i++) begin
      di = 8'(i); we = 1'b1;
      tick();
      ef = {1'b0, (i <= 2), (i >= 14), (i == 16)};
      checks++;
      if (s_count !== 5'(i)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_count, i);
      end
      checks++;
      if ({s_empty, s_ae, s_af, s_full} !== ef) begin
        errors++; $display("FAIL fill_flags[%0d]: got %b want %b", i, {s_empty, s_ae, s_af, s_full}, ef);
      end
    end
    checks++;
    if (s_ovf !== 1'b0) begin
      errors++; $display("FAIL fill_no_ovf: got %b want 0", s_ovf);
    end
    di = 8'h11;
    tick();
    we = 1'b0;
    checks++;
    if (s_count !== 5'd16 || s_ovf !== 1'b1 || s_full !== 1'b1) begin
      errors++; $display("FAIL fill_overflow: got count=%0d ovf=%b full=%b want 16 1 1",
                          s_count, s_ovf, s_full);
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 16; k++) begin
      re = 1'b1;
      tick();
      checks++;
      if (s_dout !== 8'(k) || s_rv !== 1'b1) begin
        errors++; $display("FAIL drain_data[%0d]: got dout=%h rv=%b want %h 1", k, s_dout, s_rv, 8'(k));
      end
      checks++;
      if (s_count !== 5'(16 - k) || s_empty !== (k == 16)) begin
        errors++; $display("FAIL drain_count[%0d]: got count=%0d empty=%b want %0d %b",
                            k, s_count, s_empty, 16 - k, (k == 16));
      end
    end
    checks++;
    if (s_udf !== 1'b0) begin
      errors++; $display("FAIL drain_no_udf: got %b want 0", s_udf);
    end
    tick();
    re = 1'b0;
    checks++;
    if (s_udf !== 1'b1 || s_rv !== 1'b0 || s_dout !== 8'h10 || s_count !== 5'd0) begin
      errors++; $display("FAIL drain_underflow: got udf=%b rv=%b dout=%h count=%0d want 1 0 10 0",
                          s_udf, s_rv, s_dout, s_count);
    end
    checks++;
    if (s_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got %b want 1", s_ovf);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      di = 8'(8'h20 + i); we = 1'b1;
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      di = 8'(8'h25 + j); we = 1'b1; re = 1'b1;
      tick();
      checks++;
      if (s_dout !== 8'(8'h20 + j) || s_rv !== 1'b1) begin
        errors++; $display("FAIL simul_data[%0d]: got dout=%h rv=%b want %h 1", j, s_dout, s_rv, 8'(8'h20 + j));
      end
      checks++;
      if (s_count !== 5'd5 || {s_empty, s_ae, s_af, s_full} !== 4'b0000) begin
        errors++; $display("FAIL simul_state[%0d]: got count=%0d flags=%b want 5 0000",
                            j, s_count, {s_empty, s_ae, s_af, s_full});
      end
    end
    we = 1'b0;
    for (int j = 0; j < 5; j++) begin
      re = 1'b1;
      tick();
      checks++;
      if (s_dout !== 8'(8'h2A + j)) begin
        errors++; $display("FAIL simul_tail[%0d]: got %h want %h", j, s_dout, 8'(8'h2A + j));
      end
    end
    re = 1'b0;
    checks++;
    if (s_empty !== 1'b1 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin
      errors++; $display("FAIL simul_end: got empty=%b ovf=%b udf=%b want 1 0 0", s_empty, s_ovf, s_udf);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      di = 8'(i); we = 1'b1;
      tick();
    end
    di = 8'hFF; we = 1'b1; re = 1'b1;
    tick();
    checks++;
    if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_dout !== 8'h01 || s_rv !== 1'b1) begin
      errors++; $display("FAIL full_both: got count=%0d ovf=%b dout=%h rv=%b want 15 1 01 1",
                          s_count, s_ovf, s_dout, s_rv);
    end
    we = 1'b0;
    for (int k = 2; k <= 16; k++) tick();
    re = 1'b0;
    checks++;
    if (s_dout !== 8'h10 || s_count !== 5'd0 || s_udf !== 1'b0) begin
      errors++; $display("FAIL full_both_drain: got dout=%h count=%0d udf=%b want 10 0 0",
                          s_dout, s_count, s_udf);
    end
    di = 8'h77; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    checks++;
    if (s_count !== 5'd1 || s_udf !== 1'b1 || s_rv !== 1'b0 || s_empty !== 1'b0) begin
      errors++; $display("FAIL empty_both: got count=%0d udf=%b rv=%b empty=%b want 1 1 0 0",
                          s_count, s_udf, s_rv, s_empty);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++;
    if (s_dout !== 8'h77 || s_rv !== 1'b1) begin
      errors++; $display("FAIL empty_both_read: got dout=%h rv=%b want 77 1", s_dout, s_rv);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       wa, ra;
    int         wr_n, rd_n, cnt, cyc;
    wr_n = 0; rd_n = 0; cnt = 0; cyc = 0; exp_d = 8'h00;
    do_reset();
    while (rd_n < 50 && cyc < 600) begin
      we = (wr_n < 50) && ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 1) == 1) || (wr_n == 50);
      di = 8'(wr_n + 1);
      wa = we && (cnt != 16);
      ra = re && (cnt != 0);
      if (ra) exp_d = q.pop_front();
      if (wa) begin
        q.push_back(di);
        wr_n++;
      end
      cnt = cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
      tick();
      checks++;
      if (s_count !== 5'(cnt)) begin
        errors++; $display("FAIL wrap_count[cyc %0d]: got %0d want %0d", cyc, s_count, cnt);
      end
      if (ra) begin
        rd_n++;
        checks++;
        if (s_dout !== exp_d || s_rv !== 1'b1) begin
          errors++; $display("FAIL wrap_data[%0d]: got dout=%h rv=%b want %h 1", rd_n, s_dout, s_rv, exp_d);
        end
      end
      cyc++;
    end
    we = 1'b0; re = 1'b0;
    checks++;
    if (rd_n != 50) begin
      errors++; $display("FAIL wrap_timeout: got %0d words read want 50", rd_n);
    end
  endtask

  task automatic test_fwft_reset();
    do_reset();
    di = 8'hA5; we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if (f_empty !== 1'b0 || f_rv !== 1'b1 || f_dout !== 8'hA5) begin
      errors++; $display("FAIL fwft_first: got empty=%b rv=%b dout=%h want 0 1 a5", f_empty, f_rv, f_dout);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++;
    if (f_empty !== 1'b1 || f_rv !== 1'b0 || f_count !== 5'd0) begin
      errors++; $display("FAIL fwft_pop: got empty=%b rv=%b count=%0d want 1 0 0", f_empty, f_rv, f_count);
    end
    for (int i = 0; i < 7; i++) begin
      di = 8'(8'h50 + i); we = 1'b1;
      tick();
    end
    we = 1'b0;
    checks++;
    if (f_dout !== 8'h50 || f_count !== 5'd7) begin
      errors++; $display("FAIL fwft_head: got dout=%h count=%0d want 50 7", f_dout, f_count);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++;
    if (f_dout !== 8'h51 || f_count !== 5'd6 || f_rv !== 1'b1) begin
      errors++; $display("FAIL fwft_next: got dout=%h count=%0d rv=%b want 51 6 1", f_dout, f_count, f_rv);
    end
    di = 8'h57; we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if (f_count !== 5'd7) begin
      errors++; $display("FAIL fwft_count7: got %0d want 7", f_count);
    end
    do_reset();
    checks++;
    if (f_count !== 5'd0 || {f_empty, f_ae, f_af, f_full} !== 4'b1100) begin
      errors++; $display("FAIL fwft_reset_state: got count=%0d flags=%b want 0 1100",
                          f_count, {f_empty, f_ae, f_af, f_full});
    end
    checks++;
    if ({f_dout, f_rv, f_ovf, f_udf} !== 11'd0) begin
      errors++; $display("FAIL fwft_reset_outputs: got dout=%h rv=%b ovf=%b udf=%b want all 0",
                          f_dout, f_rv, f_ovf, f_udf);
    end
    di = 8'h3C; we = 1'b1;
    tick();
    we = 1'b0;
    checks++;
    if (f_dout !== 8'h3C || f_rv !== 1'b1 || f_count !== 5'd1) begin
      errors++; $display("FAIL fwft_after_reset: got dout=%h rv=%b count=%0d want 3c 1 1",
                          f_dout, f_rv, f_count);
    end
    re = 1'b1;
    tick();
    re = 1'b0;
    checks++;
    if (f_empty !== 1'b1 || f_udf !== 1'b0) begin
      errors++; $display("FAIL fwft_final_pop: got empty=%b udf=%b want 1 0", f_empty, f_udf);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; di = 8'h00;
    tick();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_boundary();
    test_wrap();
    test_fwft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
